// File: rtl/rram_cmd_sequencer.sv
// rtl/rram_cmd_sequencer.sv - RRAM host command sequencer driving CE/CLE/ALE/cmd/address/data pins
// Optional feature macro: RRAM_WRITE_VERIFY_EN (read-back verify after each write)
module rram_cmd_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int CMD_HOLD    = 2,
    parameter int ALE_CYC     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              ce,
    output logic              cle,
    output logic              ale,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        dq_o,
    output logic              dq_oe,
    input  logic [7:0]        dq_i,
    input  logic              dev_ready,
    output logic              busy
);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PH_MAX = (CMD_HOLD > ALE_CYC) ? CMD_HOLD : ALE_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  CMD_LAST = PH_W'(CMD_HOLD - 1);
    localparam logic [PH_W-1:0]  ALE_LAST = PH_W'(ALE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYC);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FORM  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TO  = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;
`ifdef RRAM_WRITE_VERIFY_EN
    localparam logic [1:0] ERR_VFY = 2'b11;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_CMD1, S_CMD2, S_ADDR, S_DATA, S_WAIT, S_RESP, S_VGAP
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d, wcnt_inc;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              vfy_q, vfy_d;
    logic              rd_phase;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic              ce_q, ce_d, cle_q, cle_d, ale_q, ale_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_o_q, addr_o_d;
    logic [7:0]        dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              busy_q, busy_d;

    // The verify pass of a write reuses the read path (cmd 0001, no CMD2, no DATA).
    assign rd_phase = (op_q == OP_READ) || vfy_q;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        wcnt_d      = '0;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        vfy_d       = vfy_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wcnt_inc    = (wcnt_q == TO_MAX) ? wcnt_q : wcnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_op == OP_ILL) begin
                        state_d     = S_RESP;
                        rsp_err_d   = ERR_ILL;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = S_SEL;
                    end
                end
            end
            S_SEL: begin
                state_d = S_CMD1;
                ph_d    = '0;
            end
            S_CMD1: begin
                if (ph_q == CMD_LAST) begin
                    ph_d    = '0;
                    state_d = rd_phase ? S_ADDR : S_CMD2;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_CMD2: begin
                if (ph_q == CMD_LAST) begin
                    ph_d    = '0;
                    state_d = S_ADDR;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_ADDR: begin
                if (ph_q == ALE_LAST) begin
                    ph_d    = '0;
                    state_d = (op_q == OP_WRITE && !rd_phase) ? S_DATA : S_WAIT;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_DATA: state_d = S_WAIT;
            S_WAIT: begin
                wcnt_d = wcnt_inc;
                // The first WAIT cycle (count 0) never completes, whatever dev_ready says.
                if (wcnt_q != '0 && dev_ready) begin
`ifdef RRAM_WRITE_VERIFY_EN
                    if (op_q == OP_WRITE && !vfy_q) begin
                        state_d = S_VGAP;
                        vfy_d   = 1'b1;
                    end else begin
                        state_d     = S_RESP;
                        rsp_rdata_d = rd_phase ? dq_i : 8'h00;
                        rsp_err_d   = (vfy_q && dq_i != wdata_q) ? ERR_VFY : ERR_OK;
                    end
`else
                    state_d     = S_RESP;
                    rsp_rdata_d = rd_phase ? dq_i : 8'h00;
                    rsp_err_d   = ERR_OK;
`endif
                end else if (wcnt_inc == TO_MAX) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = ERR_TO;
                end
            end
            S_VGAP: state_d = S_SEL;
            S_RESP: begin
                state_d = S_IDLE;
                vfy_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        ce_d        = (state_d == S_IDLE) || (state_d == S_RESP) || (state_d == S_VGAP);
        cle_d       = (state_d == S_CMD1) || (state_d == S_CMD2);
        ale_d       = (state_d == S_ADDR);
        dq_oe_d     = (state_d == S_DATA);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
        addr_o_d    = ale_d ? addr_d : addr_o_q;
        dq_o_d      = dq_oe_d ? wdata_q : dq_o_q;

        // CMD1 -> CMD2 is a direct nibble swap; cmd only clears while deselected.
        if (ce_d) begin
            cmd_d = 4'b0000;
        end else if (state_d == S_CMD1) begin
            if (rd_phase)              cmd_d = 4'b0001;
            else if (op_q == OP_WRITE) cmd_d = 4'b0100;
            else                       cmd_d = 4'b0111;
        end else if (state_d == S_CMD2) begin
            cmd_d = (op_q == OP_FORM) ? 4'b0110 : 4'b0010;
        end else begin
            cmd_d = cmd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            wcnt_q      <= '0;
            op_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            vfy_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 2'b00;
            ce_q        <= 1'b1;
            cle_q       <= 1'b0;
            ale_q       <= 1'b0;
            cmd_q       <= 4'b0000;
            addr_o_q    <= '0;
            dq_o_q      <= 8'h00;
            dq_oe_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            wcnt_q      <= wcnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vfy_q       <= vfy_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ce_q        <= ce_d;
            cle_q       <= cle_d;
            ale_q       <= ale_d;
            cmd_q       <= cmd_d;
            addr_o_q    <= addr_o_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ce        = ce_q;
    assign cle       = cle_q;
    assign ale       = ale_q;
    assign cmd       = cmd_q;
    assign addr_o    = addr_o_q;
    assign dq_o      = dq_o_q;
    assign dq_oe     = dq_oe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rram_cmd_sequencer.sv
// tb/tb_rram_cmd_sequencer.sv - self-checking bench for rram_cmd_sequencer
module tb_rram_cmd_sequencer;
    localparam int HOLD = 2;
    localparam int ALEC = 2;
    localparam int TO   = 255;
`ifdef RRAM_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic       clk, rst_n, req_valid, req_ready, rsp_valid;
    logic [1:0] req_op, rsp_err;
    logic [7:0] req_addr, req_wdata, rsp_rdata, addr_o, dq_o, dq_i;
    logic       ce, cle, ale, dq_oe, dev_ready, busy;
    logic [3:0] cmd;

    int checks = 0;
    int errors = 0;
    logic [26:0] trace_q[$];
    logic [26:0] exp_q[$];

    rram_cmd_sequencer #(.ADDR_W(8), .CMD_HOLD(HOLD), .ALE_CYC(ALEC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ce(ce), .cle(cle), .ale(ale), .cmd(cmd), .addr_o(addr_o),
        .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i), .dev_ready(dev_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] ent(input bit bsy, input bit rdy, input bit rv, input bit c,
                                        input bit cl, input bit al, input bit oe,
                                        input logic [3:0] cm, input logic [7:0] a, input logic [7:0] d);
        return {bsy, rdy, rv, c, cl, al, oe, cm, a, d};
    endfunction

    // One device access pass: select, command nibble(s), address, optional data, wait.
    task automatic add_phase(input logic [3:0] c1, input bit has2, input logic [3:0] c2,
                             input logic [7:0] a, input bit wr, input logic [7:0] w,
                             input int ra, output bit ok);
        logic [3:0] last;
        int nw;
        last = has2 ? c2 : c1;
        ok = (ra >= 2 && ra <= TO);
        nw = ok ? ra : TO;
        exp_q.push_back(ent(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00));
        repeat (HOLD) exp_q.push_back(ent(1, 0, 0, 0, 1, 0, 0, c1, 8'h00, 8'h00));
        if (has2) repeat (HOLD) exp_q.push_back(ent(1, 0, 0, 0, 1, 0, 0, c2, 8'h00, 8'h00));
        repeat (ALEC) exp_q.push_back(ent(1, 0, 0, 0, 0, 1, 0, last, a, 8'h00));
        if (wr) exp_q.push_back(ent(1, 0, 0, 0, 0, 0, 1, last, 8'h00, w));
        repeat (nw) exp_q.push_back(ent(1, 0, 0, 0, 0, 0, 0, last, 8'h00, 8'h00));
    endtask

    task automatic build_exp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] w,
                             input int ra0, input int ra1, input logic [7:0] v0, input logic [7:0] v1,
                             output logic [7:0] erd, output logic [1:0] eerr);
        bit ok, ok2;
        exp_q.delete();
        erd = 8'h00;
        eerr = 2'b00;
        if (op == 2'b11) begin
            eerr = 2'b10;
        end else if (op == 2'b00) begin
            add_phase(4'h1, 0, 4'h0, a, 0, w, ra0, ok);
            erd  = ok ? v0 : 8'h00;
            eerr = ok ? 2'b00 : 2'b01;
        end else if (op == 2'b10) begin
            add_phase(4'h7, 1, 4'h6, a, 0, w, ra0, ok);
            eerr = ok ? 2'b00 : 2'b01;
        end else begin
            add_phase(4'h4, 1, 4'h2, a, 1, w, ra0, ok);
            eerr = ok ? 2'b00 : 2'b01;
            if (ok && VFY) begin
                exp_q.push_back(ent(1, 0, 0, 1, 0, 0, 0, 4'h0, 8'h00, 8'h00));
                add_phase(4'h1, 0, 4'h0, a, 0, w, ra1, ok2);
                erd  = ok2 ? v1 : 8'h00;
                eerr = !ok2 ? 2'b01 : (v1 == w) ? 2'b00 : 2'b11;
            end
        end
        exp_q.push_back(ent(1, 0, 1, 1, 0, 0, 0, 4'h0, 8'h00, 8'h00));
        exp_q.push_back(ent(0, 1, 0, 1, 0, 0, 0, 4'h0, 8'h00, 8'h00));
    endtask

    // Issues one request, plays the device, records one pin snapshot per cycle after acceptance.
    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] w,
                         input int ra0, input int ra1, input logic [7:0] v0, input logic [7:0] v1,
                         input bit stop_on_ale, output int lat, output logic [7:0] rd,
                         output logic [1:0] er, output bit got);
        int n, phase, widx, ra, cyc;
        bit seen_ale, prev_ale, waiting, done;
        trace_q.delete();
        lat = 0; rd = 8'h00; er = 2'b00; got = 0;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_wait req_ready %b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        phase = -1; widx = 0; seen_ale = 0; prev_ale = 0; done = 0; cyc = 1;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 1'b0;
                req_op = 2'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
            end
            cyc++;
            trace_q.push_back(ent(busy, req_ready, rsp_valid, ce, cle, ale, dq_oe, cmd,
                                  ale ? addr_o : 8'h00, dq_oe ? dq_o : 8'h00));
            if (got) done = 1;
            else if (rsp_valid) begin
                got = 1; lat = cyc; rd = rsp_rdata; er = rsp_err;
            end
            if (stop_on_ale && ale) done = 1;
            if (ale && !prev_ale) begin phase++; widx = 0; seen_ale = 1; end
            if (ce) seen_ale = 0;
            prev_ale = ale;
            waiting = !ce && !cle && !ale && !dq_oe && seen_ale;
            dev_ready = 1'($urandom);
            dq_i = 8'($urandom);
            if (waiting) begin
                widx++;
                ra = (phase == 0) ? ra0 : ra1;
                if (widx == ra) begin
                    dev_ready = 1'b1;
                    dq_i = (phase == 0) ? v0 : v1;
                end else if (widx > 1) begin
                    dev_ready = 1'b0;
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL op_budget op %0d no response within cycle budget", op);
        end
    endtask

    function automatic int trace_diff();
        int n;
        n = (trace_q.size() < exp_q.size()) ? trace_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (trace_q[i] !== exp_q[i]) return i;
        if (trace_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        checks++;
        if ({ce, cle, ale, dq_oe, rsp_valid, busy, req_ready} !== 7'b1000001) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 1000001", {ce, cle, ale, dq_oe, rsp_valid, busy, req_ready});
        end
        checks++;
        if ({cmd, addr_o, dq_o, rsp_rdata, rsp_err} !== 34'h0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", {cmd, addr_o, dq_o, rsp_rdata, rsp_err});
        end
    endtask

    task automatic test_read();
        int lat, d; logic [7:0] rd, erd; logic [1:0] er, eer; bit got;
        build_exp(2'b00, 8'h5A, 8'h00, 3, 0, 8'hC3, 8'h00, erd, eer);
        do_op(2'b00, 8'h5A, 8'h00, 3, 0, 8'hC3, 8'h00, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL read_trace at %0d got %h required %h", d,
                     (d < trace_q.size()) ? trace_q[d] : 27'h0, (d < exp_q.size()) ? exp_q[d] : 27'h0);
        end
        checks++;
        if (!got || rd !== 8'hC3 || rd !== erd) begin errors++; $display("FAIL read_rdata got %h required %h", rd, erd); end
        checks++;
        if (er !== eer) begin errors++; $display("FAIL read_err got %b required %b", er, eer); end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL read_latency got %0d required 10", lat); end
    endtask

    task automatic test_write();
        int lat, d, ra0, ra1; logic [7:0] rd, erd; logic [1:0] er, eer; bit got;
        ra0 = $urandom_range(2, 8); ra1 = $urandom_range(2, 8);
        build_exp(2'b01, 8'h10, 8'hA5, ra0, ra1, 8'h00, 8'hA5, erd, eer);
        do_op(2'b01, 8'h10, 8'hA5, ra0, ra1, 8'h00, 8'hA5, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL write_trace at %0d got %h required %h", d,
                     (d < trace_q.size()) ? trace_q[d] : 27'h0, (d < exp_q.size()) ? exp_q[d] : 27'h0);
        end
        checks++;
        if (!got || rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL write_rsp got %h/%b required %h/%b", rd, er, erd, eer);
        end
    endtask

    task automatic test_forming_timeout();
        int lat, d; logic [7:0] rd, erd; logic [1:0] er, eer; bit got;
        build_exp(2'b10, 8'h33, 8'h00, 0, 0, 8'h00, 8'h00, erd, eer);
        do_op(2'b10, 8'h33, 8'h00, 0, 0, 8'h00, 8'h00, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL form_trace at %0d got %h required %h", d,
                     (d < trace_q.size()) ? trace_q[d] : 27'h0, (d < exp_q.size()) ? exp_q[d] : 27'h0);
        end
        checks++;
        if (!got || er !== 2'b01 || rd !== 8'h00) begin
            errors++; $display("FAIL form_timeout_rsp got %h/%b required 00/01", rd, er);
        end
        checks++;
        if (lat != 1 + 1 + 2 * HOLD + ALEC + TO + 1) begin
            errors++; $display("FAIL form_latency got %0d required %0d", lat, 1 + 1 + 2 * HOLD + ALEC + TO + 1);
        end
    endtask

    task automatic test_illegal();
        int lat, d; logic [7:0] rd, erd; logic [1:0] er, eer; bit got;
        build_exp(2'b11, 8'h77, 8'h11, 2, 2, 8'h00, 8'h00, erd, eer);
        do_op(2'b11, 8'h77, 8'h11, 2, 2, 8'h00, 8'h00, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL illegal_trace at %0d got %h required %h", d,
                     (d < trace_q.size()) ? trace_q[d] : 27'h0, (d < exp_q.size()) ? exp_q[d] : 27'h0);
        end
        checks++;
        if (!got || er !== 2'b10 || lat != 2) begin
            errors++; $display("FAIL illegal_rsp got err %b lat %0d required 10 lat 2", er, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, d; logic [7:0] rd, erd; logic [1:0] er, eer; bit got, saw_rsp;
        do_op(2'b00, 8'h81, 8'h00, 3, 0, 8'h44, 8'h00, 1, lat, rd, er, got);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ce, ale, cle, cmd, rsp_valid, busy, req_ready} !== 10'b1000000001) begin
            errors++;
            $display("FAIL async_reset got %b required 1000000001", {ce, ale, cle, cmd, rsp_valid, busy, req_ready});
        end
        saw_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rsp_valid) saw_rsp = 1;
        checks++;
        if (saw_rsp) begin errors++; $display("FAIL reset_no_rsp got rsp_valid 1 required 0"); end
        build_exp(2'b00, 8'h29, 8'h00, 4, 0, 8'h96, 8'h00, erd, eer);
        do_op(2'b00, 8'h29, 8'h00, 4, 0, 8'h96, 8'h00, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0 || !got || rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL post_reset_read diff %0d got %h/%b required %h/%b", d, rd, er, erd, eer);
        end
    endtask

    task automatic test_random();
        int lat, d, ra0, ra1; logic [7:0] rd, erd, a, w, v0, v1; logic [1:0] op, er, eer; bit got;
        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom); a = 8'($urandom); w = 8'($urandom); v0 = 8'($urandom);
            v1 = ($urandom_range(0, 1) == 0) ? w : 8'($urandom);
            ra0 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(2, 12);
            ra1 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(2, 12);
            build_exp(op, a, w, ra0, ra1, v0, v1, erd, eer);
            do_op(op, a, w, ra0, ra1, v0, v1, 0, lat, rd, er, got);
            d = trace_diff();
            checks++;
            if (d >= 0) begin
                errors++;
                $display("FAIL rand_trace op#%0d op %0d at %0d got %h required %h", k, op, d,
                         (d < trace_q.size()) ? trace_q[d] : 27'h0, (d < exp_q.size()) ? exp_q[d] : 27'h0);
            end
            checks++;
            if (!got || rd !== erd || er !== eer || lat != exp_q.size()) begin
                errors++;
                $display("FAIL rand_rsp op#%0d got %h/%b lat %0d required %h/%b lat %0d",
                         k, rd, er, lat, erd, eer, exp_q.size());
            end
        end
    endtask

`ifdef RRAM_WRITE_VERIFY_EN
    task automatic test_verify();
        int lat, d; logic [7:0] rd, erd; logic [1:0] er, eer; bit got;
        build_exp(2'b01, 8'h42, 8'h3C, 3, 4, 8'h00, 8'h38, erd, eer);
        do_op(2'b01, 8'h42, 8'h3C, 3, 4, 8'h00, 8'h38, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0 || !got || rd !== 8'h38 || er !== 2'b11) begin
            errors++; $display("FAIL verify_mismatch diff %0d got %h/%b required 38/11", d, rd, er);
        end
        build_exp(2'b01, 8'h42, 8'h3C, 2, 2, 8'h00, 8'h3C, erd, eer);
        do_op(2'b01, 8'h42, 8'h3C, 2, 2, 8'h00, 8'h3C, 0, lat, rd, er, got);
        d = trace_diff();
        checks++;
        if (d >= 0 || !got || rd !== 8'h3C || er !== 2'b00) begin
            errors++; $display("FAIL verify_match diff %0d got %h/%b required 3c/00", d, rd, er);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 8'h00; req_wdata = 8'h00;
        dq_i = 8'h00; dev_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_read();
        test_write();
        test_forming_timeout();
        test_illegal();
        test_reset_mid_op();
`ifdef RRAM_WRITE_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
